// File: rtl/twiddle_cmult_pkg.sv
// Shared FFT datapath sizing: default component widths and the full-precision
// complex-multiply output width used by the twiddle stage and the rounder after it.
package twiddle_cmult_pkg;

    localparam int FFT_DW = 16;
    localparam int FFT_TW = 16;

    // One extra bit over DW+TW covers the (-1)*(-1) + (-1)*(-1) sum.
    function automatic int cmult_ow(input int dw, input int tw);
        return dw + tw + 1;
    endfunction

    localparam int FFT_OW = cmult_ow(FFT_DW, FFT_TW);

endpackage

// File: rtl/pipe_stage_ctl.sv
// Valid/advance control for one elastic pipeline stage; the stage refills
// whenever it is empty or its contents move on downstream.
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst,
    input  logic i_up_valid,
    input  logic i_dn_ready,
    output logic o_valid,
    output logic o_ready,
    output logic o_load
);

    logic r_valid;

    assign o_valid = r_valid;
    assign o_ready = !r_valid || i_dn_ready;
    assign o_load  = i_up_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= 1'b0;
        else if (o_ready)
            r_valid <= i_up_valid;
    end

endmodule

// File: rtl/twiddle_cmult.sv
// Exact complex multiply of a data sample by a twiddle factor, three-stage
// elastic pipeline, full-precision output with frame-last sideband.
module twiddle_cmult
    import twiddle_cmult_pkg::*;
#(
    parameter int DW = FFT_DW,
    parameter int TW = FFT_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic [TW-1:0] tw_re,
    input  logic [TW-1:0] tw_im,
    input  logic          in_bypass,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [cmult_ow(DW, TW)-1:0] out_re,
    output logic [cmult_ow(DW, TW)-1:0] out_im,
    output logic          out_last
);

    localparam int OW = cmult_ow(DW, TW);
    localparam int PW = DW + TW;

    logic w_v1, w_v2, w_v3;
    logic w_rdy1, w_rdy2, w_rdy3;
    logic w_ld1, w_ld2, w_ld3;

    pipe_stage_ctl u_s1 (.clk(clk), .rst(rst), .i_up_valid(in_valid), .i_dn_ready(w_rdy2),
                         .o_valid(w_v1), .o_ready(w_rdy1), .o_load(w_ld1));
    pipe_stage_ctl u_s2 (.clk(clk), .rst(rst), .i_up_valid(w_v1), .i_dn_ready(w_rdy3),
                         .o_valid(w_v2), .o_ready(w_rdy2), .o_load(w_ld2));
    pipe_stage_ctl u_s3 (.clk(clk), .rst(rst), .i_up_valid(w_v2), .i_dn_ready(out_ready),
                         .o_valid(w_v3), .o_ready(w_rdy3), .o_load(w_ld3));

    assign in_ready  = w_rdy1 && !rst;
    assign out_valid = w_v3;

    // S1: register the raw operands
    logic [DW-1:0] r_s1_re, r_s1_im;
    logic [TW-1:0] r_s1_twr, r_s1_twi;
    logic          r_s1_byp, r_s1_last;

    always_ff @(posedge clk) begin
        if (w_ld1) begin
            r_s1_re   <= in_re;
            r_s1_im   <= in_im;
            r_s1_twr  <= tw_re;
            r_s1_twi  <= tw_im;
            r_s1_byp  <= in_bypass;
            r_s1_last <= in_last;
        end
    end

    // Operands widened to the product width so the multiply is exact and signed.
    logic signed [PW-1:0] w_x_re, w_x_im, w_x_twr, w_x_twi;
    logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [PW-1:0] w_byp_re, w_byp_im;

    assign w_x_re  = {{TW{r_s1_re[DW-1]}}, r_s1_re};
    assign w_x_im  = {{TW{r_s1_im[DW-1]}}, r_s1_im};
    assign w_x_twr = {{DW{r_s1_twr[TW-1]}}, r_s1_twr};
    assign w_x_twi = {{DW{r_s1_twi[TW-1]}}, r_s1_twi};

    assign w_p_rr = w_x_re * w_x_twr;
    assign w_p_ii = w_x_im * w_x_twi;
    assign w_p_ri = w_x_re * w_x_twi;
    assign w_p_ir = w_x_im * w_x_twr;

    // Bypass lands on the same binary point as a multiply by +1.0 (Q1.TW-1).
    assign w_byp_re = w_x_re <<< (TW - 1);
    assign w_byp_im = w_x_im <<< (TW - 1);

    // S2: register the four partial products (bypass routes through rr/ir)
    logic [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic          r_s2_last;

    always_ff @(posedge clk) begin
        if (w_ld2) begin
            r_p_rr    <= r_s1_byp ? w_byp_re : w_p_rr;
            r_p_ii    <= r_s1_byp ? '0       : w_p_ii;
            r_p_ri    <= r_s1_byp ? '0       : w_p_ri;
            r_p_ir    <= r_s1_byp ? w_byp_im : w_p_ir;
            r_s2_last <= r_s1_last;
        end
    end

    // S3: full-precision sum and difference
    logic [OW-1:0] r_out_re, r_out_im;
    logic          r_out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_re   <= '0;
            r_out_im   <= '0;
            r_out_last <= 1'b0;
        end else if (w_ld3) begin
            r_out_re   <= {r_p_rr[PW-1], r_p_rr} - {r_p_ii[PW-1], r_p_ii};
            r_out_im   <= {r_p_ri[PW-1], r_p_ri} + {r_p_ir[PW-1], r_p_ir};
            r_out_last <= r_s2_last;
        end
    end

    assign out_re   = r_out_re;
    assign out_im   = r_out_im;
    assign out_last = r_out_last;

endmodule
